// File: rtl/serializer_if.sv
// Valid/ready stream bundle; Width sets the data bus size. The serializer
// takes a wide instance on its slave side and drives a narrow one as master.
interface serializer_if #(
    parameter int unsigned Width = 8
);
    logic             valid;
    logic             ready;
    logic [Width-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/serializer.sv
// Wide-to-narrow stream serializer, LSB beat first by default.
// Define SERIALIZER_MSB_FIRST_EN to emit the most-significant beat first.
module serializer #(
    parameter int unsigned INLOGBITS  = 6,
    parameter int unsigned OUTLOGBITS = 3
) (
    input logic          clk,
    input logic          rst_n,
    serializer_if.slave  in_if,
    serializer_if.master out_if
);
    localparam int unsigned InWidth  = 1 << INLOGBITS;
    localparam int unsigned OutWidth = 1 << OUTLOGBITS;
    localparam int unsigned NBeats   = 1 << (INLOGBITS - OUTLOGBITS);
    localparam int unsigned CntW     = INLOGBITS - OUTLOGBITS + 1;

    typedef enum logic {StEmpty, StShifting} state_e;

    logic [InWidth-1:0] sr_q, sr_d, sr_shift;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               out_valid_q, out_valid_d;
    logic               fire_in, fire_out;
    state_e             state;

    // State is fully implied by the beat counter.
    assign state    = (cnt_q == '0) ? StEmpty : StShifting;
    assign fire_in  = in_if.valid && in_if.ready;
    assign fire_out = out_valid_q && out_if.ready;

    // Accept when empty, or when the final beat drains this same cycle.
    assign in_if.ready = (cnt_q == '0) || ((cnt_q == CntW'(1)) && out_if.ready);
    assign out_if.valid = out_valid_q;

`ifdef SERIALIZER_MSB_FIRST_EN
    assign sr_shift    = sr_q << OutWidth;
    assign out_if.data = sr_q[InWidth-1 -: OutWidth];
`else
    assign sr_shift    = sr_q >> OutWidth;
    assign out_if.data = sr_q[OutWidth-1:0];
`endif

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        unique case (state)
            StEmpty: begin
                if (fire_in) begin
                    sr_d  = in_if.data;
                    cnt_d = CntW'(NBeats);
                end
            end
            StShifting: begin
                // A new word overwrites the last beat being consumed alongside it.
                if (fire_in) begin
                    sr_d  = in_if.data;
                    cnt_d = CntW'(NBeats);
                end else if (fire_out) begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q - CntW'(1);
                end
            end
        endcase
        out_valid_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            sr_q        <= sr_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
